// File: rtl/instruction_decoder_pkg.sv
// ============================================================================
// instruction_decoder_pkg : shared opcodes, ALU encodings and control decode
// Rev 1.0
// ============================================================================
`default_nettype none

package instruction_decoder_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_SUB  = 3'b010,
        OP_SUBI = 3'b011,
        OP_LUI  = 3'b100,
        OP_BEQ  = 3'b101,
        OP_SW   = 3'b110,
        OP_LW   = 3'b111
    } opcode_t;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_lui = 3'b011;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t c_ctrl_bubble = '{alu_op: c_alu_add, default: 1'b0};

    function automatic ctrl_t decode_ctrl(input logic [2:0] opcode);
        ctrl_t ctrl;
        ctrl = c_ctrl_bubble;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                ctrl.alu_op    = c_alu_add;
                ctrl.reg_write = 1'b1;
            end
            OP_SUB, OP_SUBI: begin
                ctrl.alu_op    = c_alu_sub;
                ctrl.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_op    = c_alu_lui;
                ctrl.reg_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = c_alu_sub;
                ctrl.branch = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op    = c_alu_add;
                ctrl.mem_write = 1'b1;
            end
            default: begin
                ctrl.alu_op    = c_alu_add;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
        endcase
        return ctrl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_decoder_imm_expand.sv
// ============================================================================
// instruction_decoder_imm_expand : opcode-dependent immediate expansion
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_decoder_imm_expand
    import instruction_decoder_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [9:0]  imm_field,
    output logic [15:0] imm
);

    always_comb begin
        imm = 16'h0000;
        case (opcode)
            OP_ADDI, OP_BEQ, OP_SW, OP_LW: imm = {{9{imm_field[6]}}, imm_field[6:0]};
            OP_SUBI:                       imm = {{6{imm_field[9]}}, imm_field};
            OP_LUI:                        imm = {imm_field, 6'b000000};
            default:                       imm = 16'h0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instruction_decoder.sv
// ============================================================================
// instruction_decoder : single-stage registered 16-bit instruction decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_decoder
    import instruction_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic        in_valid,
    output logic        out_valid,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic [2:0]  rd_a,
    output logic [2:0]  rs_b,
    output logic [2:0]  rs_c,
    output logic [15:0] imm
);

    logic [15:0] w_imm;
    ctrl_t       w_ctrl;

    instruction_decoder_imm_expand u_imm_expand (
        .opcode    (instruction[15:13]),
        .imm_field (instruction[9:0]),
        .imm       (w_imm)
    );

    // Invalid cycles still carry fields and immediate, but strobes are forced to a bubble.
    always_comb begin
        w_ctrl = c_ctrl_bubble;
        if (in_valid) begin
            w_ctrl = decode_ctrl(instruction[15:13]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_op    <= 3'b000;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            rd_a      <= 3'b000;
            rs_b      <= 3'b000;
            rs_c      <= 3'b000;
            imm       <= 16'h0000;
        end else begin
            out_valid <= in_valid;
            alu_op    <= w_ctrl.alu_op;
            reg_write <= w_ctrl.reg_write;
            mem_read  <= w_ctrl.mem_read;
            mem_write <= w_ctrl.mem_write;
            branch    <= w_ctrl.branch;
            jump      <= w_ctrl.jump;
            rd_a      <= instruction[12:10];
            rs_b      <= instruction[9:7];
            rs_c      <= instruction[2:0];
            imm       <= w_imm;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_decoder.sv
// ============================================================================
// tb_instruction_decoder : directed + random check against a table-driven model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic        in_valid;
    logic        out_valid;
    logic [2:0]  alu_op;
    logic        reg_write, mem_read, mem_write, branch, jump;
    logic [2:0]  rd_a, rs_b, rs_c;
    logic [15:0] imm;

    int n_checks = 0;
    int n_errors = 0;

    instruction_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .in_valid    (in_valid),
        .out_valid   (out_valid),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
        .rd_a        (rd_a),
        .rs_b        (rs_b),
        .rs_c        (rs_c),
        .imm         (imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ov;
        logic [2:0]  alu;
        logic        rw, mr, mw, br, jp;
        logic [2:0]  a, b, c;
        logic [15:0] imm;
    } exp_t;

    // Decode table rows indexed by opcode value.
    int alu_tab [8] = '{0, 0, 1, 1, 3, 1, 0, 0};
    int rw_tab  [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
    int mr_tab  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int mw_tab  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int br_tab  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

    function automatic exp_t model(input logic [15:0] ins, input logic v, input logic r);
        exp_t e;
        int   op;
        int   val;
        e = '{ov: 1'b0, alu: 3'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, jp: 1'b0,
              a: 3'd0, b: 3'd0, c: 3'd0, imm: 16'd0};
        if (r) return e;
        op    = int'(ins[15:13]);
        e.ov  = v;
        e.a   = ins[12:10];
        e.b   = ins[9:7];
        e.c   = ins[2:0];
        if (v) begin
            e.alu = 3'(alu_tab[op]);
            e.rw  = 1'(rw_tab[op]);
            e.mr  = 1'(mr_tab[op]);
            e.mw  = 1'(mw_tab[op]);
            e.br  = 1'(br_tab[op]);
        end
        val = 0;
        case (op)
            1, 5, 6, 7: begin
                val = int'(ins[6:0]);
                if (val >= 64) val = val - 128;
            end
            3: begin
                val = int'(ins[9:0]);
                if (val >= 512) val = val - 1024;
            end
            4: val = int'(ins[9:0]) * 64;
            default: val = 0;
        endcase
        e.imm = 16'(val);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [15:0] ins, input logic v, input logic r, input string tag);
        exp_t e;
        instruction = ins;
        in_valid    = v;
        rst         = r;
        e = model(ins, v, r);
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
        check({tag, ".alu_op"},    32'(alu_op),    32'(e.alu));
        check({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
        check({tag, ".mem_read"},  32'(mem_read),  32'(e.mr));
        check({tag, ".mem_write"}, 32'(mem_write), 32'(e.mw));
        check({tag, ".branch"},    32'(branch),    32'(e.br));
        check({tag, ".jump"},      32'(jump),      32'(e.jp));
        check({tag, ".rd_a"},      32'(rd_a),      32'(e.a));
        check({tag, ".rs_b"},      32'(rs_b),      32'(e.b));
        check({tag, ".rs_c"},      32'(rs_c),      32'(e.c));
        check({tag, ".imm"},       32'(imm),       32'(e.imm));
    endtask

    initial begin
        logic [15:0] ins;
        instruction = 16'hFFFF;
        in_valid    = 1'b1;
        rst         = 1'b1;

        step(16'hFFFF, 1'b1, 1'b1, "reset0");
        step(16'hABCD, 1'b1, 1'b1, "reset1");

        step(16'b000_001_010_0000_001, 1'b1, 1'b0, "add");
        check("add.imm_literal", 32'(imm), 32'h0000);
        step(16'b011_001_1111111111,   1'b1, 1'b0, "subi");
        check("subi.imm_literal", 32'(imm), 32'hFFFF);
        step(16'b100_010_011_1111111,  1'b1, 1'b0, "lui");
        check("lui.imm_literal", 32'(imm), 32'h7FC0);
        step(16'b101_100_101_0000001,  1'b1, 1'b0, "beq");
        step(16'b110_101_110_0000100,  1'b1, 1'b0, "sw");
        check("sw.imm_literal", 32'(imm), 32'h0004);
        step(16'b111_111_000_0000000,  1'b1, 1'b0, "lw");
        step(16'b111_111_000_0000000,  1'b0, 1'b0, "lw_invalid");

        for (int k = 0; k < 8; k++) begin
            ins = {3'(k), 13'($urandom)};
            step(ins, 1'b1, (k == 5), "stream");
        end
        step(16'b000_001_010_0000_001, 1'b0, 1'b0, "post_rst_idle");
        step(16'b111_001_010_1000000,  1'b1, 1'b0, "post_rst_first");

        for (int k = 0; k < 400; k++) begin
            ins = 16'($urandom);
            step(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
